// File: rtl/err_inj_chk.sv
// -----------------------------------------------------------------------------
// err_inj_chk
//   Checks lockstep comparator responses against injected error masks.
//   Each one-hot injected mask is delayed by the comparator response latency
//   and compared with the raw comparator mismatch flags. Every injected bit must
//   be detected, and no other bit may fire. Per-bit results are accumulated and
//   a dual-rail done/pass verdict is reported to the safety controller.
//
//   Optional feature: define ERR_INJ_CHK_TIMEOUT_EN to enable an 8-bit
//   watchdog that ends a RUN phase lasting TIMEOUT_CYC cycles with a failing
//   verdict. Without the macro, timeout is tied low.
//
// Ports
//   clk                  in   clock
//   rst_n                in   async active-low reset
//   error_mask_sc        in   one-hot injected error bit (0 = not injecting)
//   valid_mask_sc        in   bits still under test
//   dr_sfty_diag_inj_end in   dual-rail injection end (10 true, 01 false)
//   dr_mask_pty_err      in   dual-rail mask parity error (10 error)
//   cmp_err_in           in   raw per-rail comparator mismatch flags
//   dr_sfty_diag_done    out  dual-rail check complete (reset 01)
//   dr_sfty_diag_pass    out  dual-rail verdict, valid when done = 10 (reset 01)
//   miss_vec             out  injected bits never detected (sticky)
//   spur_vec             out  bits flagged without injection (sticky)
//   dr_in_err            out  invalid dual-rail input seen while checking (sticky)
//   timeout              out  watchdog expired
// -----------------------------------------------------------------------------
module err_inj_chk #(
    parameter int  NUM_COMPARATORS = 4,
    parameter int  CMP_LAT         = 2,
    parameter int  TIMEOUT_CYC     = 64,
    localparam int MASK_SIZE       = 2 * NUM_COMPARATORS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [MASK_SIZE-1:0] error_mask_sc,
    input  logic [MASK_SIZE-1:0] valid_mask_sc,
    input  logic [1:0]           dr_sfty_diag_inj_end,
    input  logic [1:0]           dr_mask_pty_err,
    input  logic [MASK_SIZE-1:0] cmp_err_in,
    output logic [1:0]           dr_sfty_diag_done,
    output logic [1:0]           dr_sfty_diag_pass,
    output logic [MASK_SIZE-1:0] miss_vec,
    output logic [MASK_SIZE-1:0] spur_vec,
    output logic                 dr_in_err,
    output logic                 timeout
);

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_RUN   = 4'b0010,
        ST_DRAIN = 4'b0100,
        ST_DONE  = 4'b1000
    } state_e;

    localparam logic [MASK_SIZE-1:0] MASK_ZERO = {MASK_SIZE{1'b0}};
    localparam logic [MASK_SIZE-1:0] MASK_ONE  = {{(MASK_SIZE-1){1'b0}}, 1'b1};
    localparam logic [2:0]           LAT_CNT   = 3'(CMP_LAT);

    // True when more than one bit of v is set.
    function automatic logic multi_hot(input logic [MASK_SIZE-1:0] v);
        return ((v & (v - MASK_ONE)) != MASK_ZERO);
    endfunction

    // Dual-rail pair is legal only when exactly one rail is high.
    function automatic logic dr_valid(input logic [1:0] v);
        return (v[1] ^ v[0]);
    endfunction

    state_e                               state_q, state_d;
    logic [2:0]                           drain_cnt_q, drain_cnt_d;
    logic [CMP_LAT-1:0][MASK_SIZE-1:0]    err_dl_q, err_dl_d;
    logic [CMP_LAT-1:0][MASK_SIZE-1:0]    vld_dl_q, vld_dl_d;
    logic [MASK_SIZE-1:0]                 seen_q, seen_d;
    logic [MASK_SIZE-1:0]                 spur_q, spur_d;
    logic [MASK_SIZE-1:0]                 miss_q, miss_d;
    logic                                 seq_err_q, seq_err_d;
    logic                                 pty_fail_q, pty_fail_d;
    logic                                 dr_in_err_q, dr_in_err_d;
    logic                                 timeout_q, timeout_d;
    logic                                 verdict_q, verdict_d;
    logic [1:0]                           done_q, done_d;
    logic [1:0]                           pass_q, pass_d;
    logic [MASK_SIZE-1:0]                 exp_err_s;
    logic [MASK_SIZE-1:0]                 exp_vld_s;
    logic                                 checking_s;
`ifdef ERR_INJ_CHK_TIMEOUT_EN
    localparam logic [7:0] WDOG_LIM = 8'(TIMEOUT_CYC - 1);
    logic [7:0]                           wdog_q, wdog_d;
`endif

    assign exp_err_s  = err_dl_q[CMP_LAT-1];
    assign exp_vld_s  = vld_dl_q[CMP_LAT-1];
    assign checking_s = (state_q == ST_RUN) || (state_q == ST_DRAIN);

    // Delay line: stage 0 always samples the inputs so the first injected bit
    // of a sequence (arriving while still IDLE) is kept; older stages are
    // flushed in IDLE so no stale mask leaks into the next check.
    always_comb begin
        err_dl_d    = err_dl_q;
        vld_dl_d    = vld_dl_q;
        err_dl_d[0] = error_mask_sc;
        vld_dl_d[0] = valid_mask_sc;
        for (int i = 1; i < CMP_LAT; i++) begin
            if (state_q == ST_IDLE) begin
                err_dl_d[i] = MASK_ZERO;
                vld_dl_d[i] = MASK_ZERO;
            end else begin
                err_dl_d[i] = err_dl_q[i-1];
                vld_dl_d[i] = vld_dl_q[i-1];
            end
        end
    end

    // Next-state, result accumulation and verdict.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        seen_d      = seen_q;
        spur_d      = spur_q;
        miss_d      = miss_q;
        seq_err_d   = seq_err_q;
        pty_fail_d  = pty_fail_q;
        dr_in_err_d = dr_in_err_q;
        timeout_d   = timeout_q;
        verdict_d   = verdict_q;
`ifdef ERR_INJ_CHK_TIMEOUT_EN
        wdog_d      = wdog_q;
`endif

        if (checking_s) begin
            seen_d = seen_q | (exp_err_s & cmp_err_in);
            spur_d = spur_q | (cmp_err_in & ~exp_err_s);
            if (((exp_err_s & ~exp_vld_s) != MASK_ZERO) || multi_hot(exp_err_s)) begin
                seq_err_d = 1'b1;
            end else begin
                seq_err_d = seq_err_q;
            end
            if ((state_q == ST_RUN) && (dr_mask_pty_err == 2'b10)) begin
                pty_fail_d = 1'b1;
            end else begin
                pty_fail_d = pty_fail_q;
            end
            if (!dr_valid(dr_sfty_diag_inj_end) || !dr_valid(dr_mask_pty_err)) begin
                dr_in_err_d = 1'b1;
            end else begin
                dr_in_err_d = dr_in_err_q;
            end
        end else begin
            seen_d = seen_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (error_mask_sc != MASK_ZERO) begin
                    state_d     = ST_RUN;
                    drain_cnt_d = 3'd0;
                    seen_d      = MASK_ZERO;
                    // A comparator firing in the very first injection cycle
                    // cannot be a response to this sequence.
                    spur_d      = cmp_err_in;
                    miss_d      = MASK_ZERO;
                    seq_err_d   = 1'b0;
                    pty_fail_d  = 1'b0;
                    dr_in_err_d = 1'b0;
                    timeout_d   = 1'b0;
                    verdict_d   = 1'b0;
`ifdef ERR_INJ_CHK_TIMEOUT_EN
                    // The start cycle counts as the first cycle of the run.
                    wdog_d      = 8'd1;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (dr_sfty_diag_inj_end == 2'b10) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = LAT_CNT;
                end else if (error_mask_sc == MASK_ZERO) begin
                    state_d = ST_IDLE;
                end else begin
`ifdef ERR_INJ_CHK_TIMEOUT_EN
                    if (wdog_q >= WDOG_LIM) begin
                        timeout_d = 1'b1;
                        state_d   = ST_DONE;
                    end else begin
                        wdog_d = wdog_q + 8'd1;
                    end
`else
                    state_d = ST_RUN;
`endif
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q <= 3'd1) begin
                    state_d     = ST_DONE;
                    drain_cnt_d = 3'd0;
                end else begin
                    drain_cnt_d = drain_cnt_q - 3'd1;
                end
            end
            ST_DONE: begin
                if ((error_mask_sc == MASK_ZERO) && (dr_sfty_diag_inj_end == 2'b01)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Verdict is frozen on the cycle the FSM enters DONE, including this
        // cycle's comparator sample.
        if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
            miss_d    = ~seen_d;
            verdict_d = (&seen_d) & ~(|spur_d) & ~seq_err_d & ~pty_fail_d
                        & ~dr_in_err_d & ~timeout_d;
        end else begin
            miss_d = miss_d;
        end

        done_d = (state_d == ST_DONE) ? 2'b10 : 2'b01;
        pass_d = ((state_d == ST_DONE) && verdict_d) ? 2'b10 : 2'b01;
    end

    // State and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            drain_cnt_q <= 3'd0;
            err_dl_q    <= {(CMP_LAT*MASK_SIZE){1'b0}};
            vld_dl_q    <= {(CMP_LAT*MASK_SIZE){1'b0}};
            seen_q      <= MASK_ZERO;
            spur_q      <= MASK_ZERO;
            miss_q      <= MASK_ZERO;
            seq_err_q   <= 1'b0;
            pty_fail_q  <= 1'b0;
            dr_in_err_q <= 1'b0;
            timeout_q   <= 1'b0;
            verdict_q   <= 1'b0;
            done_q      <= 2'b01;
            pass_q      <= 2'b01;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            err_dl_q    <= err_dl_d;
            vld_dl_q    <= vld_dl_d;
            seen_q      <= seen_d;
            spur_q      <= spur_d;
            miss_q      <= miss_d;
            seq_err_q   <= seq_err_d;
            pty_fail_q  <= pty_fail_d;
            dr_in_err_q <= dr_in_err_d;
            timeout_q   <= timeout_d;
            verdict_q   <= verdict_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
        end
    end

`ifdef ERR_INJ_CHK_TIMEOUT_EN
    // Watchdog counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= 8'd0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`endif

    assign dr_sfty_diag_done = done_q;
    assign dr_sfty_diag_pass = pass_q;
    assign miss_vec          = miss_q;
    assign spur_vec          = spur_q;
    assign dr_in_err         = dr_in_err_q;
    assign timeout           = timeout_q;

endmodule

// File: tb/tb_err_inj_chk.sv
// -----------------------------------------------------------------------------
// tb_err_inj_chk
//   Directed bench for err_inj_chk (NUM_COMPARATORS=4, CMP_LAT=2,
//   TIMEOUT_CYC=16). Walks a one-hot mask bit0..bit7 and feeds back the mask
//   delayed by two cycles as comparator response, with optional faults.
// -----------------------------------------------------------------------------
module tb_err_inj_chk;

    logic       clk;
    logic       rst_n;
    logic [7:0] error_mask_sc;
    logic [7:0] valid_mask_sc;
    logic [1:0] dr_sfty_diag_inj_end;
    logic [1:0] dr_mask_pty_err;
    logic [7:0] cmp_err_in;
    logic [1:0] dr_sfty_diag_done;
    logic [1:0] dr_sfty_diag_pass;
    logic [7:0] miss_vec;
    logic [7:0] spur_vec;
    logic       dr_in_err;
    logic       timeout;

    int n_tests;
    int n_fail;

    logic [1:0] done_h [0:127];
    logic [1:0] pass_h [0:127];

    err_inj_chk #(
        .NUM_COMPARATORS (4),
        .CMP_LAT         (2),
        .TIMEOUT_CYC     (16)
    ) u_dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .error_mask_sc        (error_mask_sc),
        .valid_mask_sc        (valid_mask_sc),
        .dr_sfty_diag_inj_end (dr_sfty_diag_inj_end),
        .dr_mask_pty_err      (dr_mask_pty_err),
        .cmp_err_in           (cmp_err_in),
        .dr_sfty_diag_done    (dr_sfty_diag_done),
        .dr_sfty_diag_pass    (dr_sfty_diag_pass),
        .miss_vec             (miss_vec),
        .spur_vec             (spur_vec),
        .dr_in_err            (dr_in_err),
        .timeout              (timeout)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Drive one walk sequence; cycle c inputs are applied #1 after edge c and
    // outputs visible during cycle c are recorded into done_h/pass_h[c].
    task automatic run_seq(input logic [7:0] stuck, input bit spur0, input int pty_cyc,
                           input int inv_cyc, input int abort_cyc, input int end_cyc,
                           input int ncyc);
        logic [7:0] em_h [0:127];
        logic [7:0] em;
        done_h[0] = dr_sfty_diag_done;
        pass_h[0] = dr_sfty_diag_pass;
        for (int c = 0; c < ncyc; c++) begin
            int b;
            b = (c < 7) ? c : 7;
            em = 8'h01 << b;
            if (c >= abort_cyc) em = 8'h00;
            em_h[c] = em;
            error_mask_sc        = em;
            valid_mask_sc        = 8'hFF << b;
            dr_sfty_diag_inj_end = (c >= end_cyc) ? 2'b10 : 2'b01;
            if (c == inv_cyc) dr_sfty_diag_inj_end = 2'b11;
            dr_mask_pty_err      = (c == pty_cyc) ? 2'b10 : 2'b01;
            cmp_err_in           = (c >= 2) ? (em_h[c-2] & ~stuck) : 8'h00;
            if (spur0 && (c == 0)) cmp_err_in = cmp_err_in | 8'h04;
            @(posedge clk); #1;
            done_h[c+1] = dr_sfty_diag_done;
            pass_h[c+1] = dr_sfty_diag_pass;
        end
    endtask

    task automatic go_idle();
        error_mask_sc        = 8'h00;
        valid_mask_sc        = 8'h00;
        dr_sfty_diag_inj_end = 2'b01;
        dr_mask_pty_err      = 2'b01;
        cmp_err_in           = 8'h00;
        repeat (3) begin
            @(posedge clk); #1;
        end
    endtask

    function automatic int count_done(input int ncyc);
        int n;
        n = 0;
        for (int c = 0; c <= ncyc; c++) begin
            if (done_h[c] == 2'b10) n++;
        end
        return n;
    endfunction

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n                = 1'b0;
        error_mask_sc        = 8'h00;
        valid_mask_sc        = 8'h00;
        dr_sfty_diag_inj_end = 2'b01;
        dr_mask_pty_err      = 2'b01;
        cmp_err_in           = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_done",    32'(dr_sfty_diag_done), 32'h1);
        check_val("rst_pass",    32'(dr_sfty_diag_pass), 32'h1);
        check_val("rst_miss",    32'(miss_vec),          32'h0);
        check_val("rst_spur",    32'(spur_vec),          32'h0);
        check_val("rst_dr_in",   32'(dr_in_err),         32'h0);
        check_val("rst_timeout", 32'(timeout),           32'h0);
        rst_n = 1'b1;
        go_idle();

        // T1: clean walk
        run_seq(8'h00, 1'b0, -1, -1, 1000, 8, 14);
        check_val("t1_done_c10", 32'(done_h[10]), 32'h1);
        check_val("t1_done_c11", 32'(done_h[11]), 32'h2);
        check_val("t1_pass_c11", 32'(pass_h[11]), 32'h2);
        check_val("t1_miss",     32'(miss_vec),   32'h00);
        check_val("t1_spur",     32'(spur_vec),   32'h00);
        check_val("t1_dr_in",    32'(dr_in_err),  32'h0);
        go_idle();
        check_val("t1_done_idle", 32'(dr_sfty_diag_done), 32'h1);

        // T2: bit5 never detected
        run_seq(8'h20, 1'b0, -1, -1, 1000, 8, 14);
        check_val("t2_done", 32'(done_h[11]), 32'h2);
        check_val("t2_pass", 32'(pass_h[11]), 32'h1);
        check_val("t2_miss", 32'(miss_vec),   32'h20);
        go_idle();

        // T3: spurious bit2 in cycle 0
        run_seq(8'h00, 1'b1, -1, -1, 1000, 8, 14);
        check_val("t3_pass", 32'(pass_h[11]), 32'h1);
        check_val("t3_spur", 32'(spur_vec),   32'h04);
        check_val("t3_miss", 32'(miss_vec),   32'h00);
        go_idle();

        // T4a: mask parity error mid-walk
        run_seq(8'h00, 1'b0, 4, -1, 1000, 8, 14);
        check_val("t4_pty_done", 32'(done_h[11]), 32'h2);
        check_val("t4_pty_pass", 32'(pass_h[11]), 32'h1);
        go_idle();

        // T4b: invalid dual-rail inj_end
        run_seq(8'h00, 1'b0, -1, 3, 1000, 8, 14);
        check_val("t4_inv_dr_in", 32'(dr_in_err),  32'h1);
        check_val("t4_inv_pass",  32'(pass_h[11]), 32'h1);
        go_idle();

        // T5a: abort at cycle 4
        run_seq(8'h00, 1'b0, -1, -1, 4, 1000, 14);
        check_val("t5_abort_no_done", 32'(count_done(14)), 32'h0);
        check_val("t5_abort_pass",    32'(dr_sfty_diag_pass), 32'h1);
        go_idle();

        // T5b: reset asserted mid-DRAIN
        run_seq(8'h00, 1'b1, -1, 3, 1000, 8, 10);
        check_val("t5_pre_spur",  32'(spur_vec),  32'h04);
        check_val("t5_pre_dr_in", 32'(dr_in_err), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check_val("t5_rst_spur",  32'(spur_vec),          32'h00);
        check_val("t5_rst_dr_in", 32'(dr_in_err),         32'h0);
        check_val("t5_rst_done",  32'(dr_sfty_diag_done), 32'h1);
        check_val("t5_rst_pass",  32'(dr_sfty_diag_pass), 32'h1);
        error_mask_sc        = 8'h00;
        dr_sfty_diag_inj_end = 2'b01;
        cmp_err_in           = 8'h00;
        @(posedge clk); #1;
        rst_n = 1'b1;
        begin
            int nd;
            nd = 0;
            repeat (6) begin
                @(posedge clk); #1;
                if (dr_sfty_diag_done == 2'b10) nd++;
            end
            check_val("t5_rst_no_done", 32'(nd), 32'h0);
        end

`ifdef ERR_INJ_CHK_TIMEOUT_EN
        // T6: watchdog fires at cycle 16
        run_seq(8'h00, 1'b0, -1, -1, 1000, 1000, 20);
        check_val("t6_done_c15", 32'(done_h[15]), 32'h1);
        check_val("t6_done_c16", 32'(done_h[16]), 32'h2);
        check_val("t6_pass_c16", 32'(pass_h[16]), 32'h1);
        check_val("t6_timeout",  32'(timeout),    32'h1);
        go_idle();
`else
        // T6: no watchdog, FSM remains in RUN
        run_seq(8'h00, 1'b0, -1, -1, 1000, 1000, 40);
        check_val("t6_no_done",    32'(count_done(40)), 32'h0);
        check_val("t6_no_timeout", 32'(timeout),        32'h0);
        // Still in RUN: raising inj_end now must complete the check.
        dr_sfty_diag_inj_end = 2'b10;
        cmp_err_in           = 8'h80;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check_val("t6_late_done", 32'(dr_sfty_diag_done), 32'h2);
        go_idle();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
